// File: rtl/pulse_channel.sv
// pulse_channel: square-wave tone generator with optional volume envelope.
// Captures a note load (period, duty, volume, decay) and emits a registered 4-bit
// PCM sample stream. Each of the 8 duty steps lasts period+1 clocks.
// Optional feature macro: PULSE_ENVELOPE_EN enables the frame-tick volume envelope
// (decay divider). Without it, i_decay and i_tick_stb are ignored.
module pulse_channel #(
   parameter int unsigned PERIOD_W = 12,
   parameter int unsigned VOL_W    = 4
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_tick_stb,
   input  logic                i_load_stb,
   input  logic                i_stop_stb,
   input  logic [PERIOD_W-1:0] i_period,
   input  logic [1:0]          i_duty,
   input  logic [VOL_W-1:0]    i_volume,
   input  logic [3:0]          i_decay,
   output logic [VOL_W-1:0]    o_sample,
   output logic                o_active
);

   typedef enum logic [0:0] {StIdle, StPlay} state_e;

   state_e              state_q, state_d;
   logic [PERIOD_W-1:0] period_q, period_d;
   logic [PERIOD_W-1:0] timer_q, timer_d;
   logic [1:0]          duty_q, duty_d;
   logic [2:0]          step_q, step_d;
   logic [VOL_W-1:0]    vol_q, vol_d;
   logic [VOL_W-1:0]    sample_q, sample_d;
   logic                active_q, active_d;
   logic                duty_hi;
   logic                is_rest;

`ifdef PULSE_ENVELOPE_EN
   logic [3:0]          decay_q, decay_d;
   logic [3:0]          div_q, div_d;
`else
   // Envelope inputs have no function in this build.
   logic                unused_env;
   assign unused_env = ^{i_decay, i_tick_stb};
`endif

   // A load with zero period or zero volume is a rest and parks the channel.
   assign is_rest = (i_period == '0) || (i_volume == '0);

   // State and datapath registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q  <= StIdle;
         period_q <= '0;
         timer_q  <= '0;
         duty_q   <= 2'd0;
         step_q   <= 3'd0;
         vol_q    <= '0;
         sample_q <= '0;
         active_q <= 1'b0;
`ifdef PULSE_ENVELOPE_EN
         decay_q  <= 4'd0;
         div_q    <= 4'd0;
`endif
      end else begin
         state_q  <= state_d;
         period_q <= period_d;
         timer_q  <= timer_d;
         duty_q   <= duty_d;
         step_q   <= step_d;
         vol_q    <= vol_d;
         sample_q <= sample_d;
         active_q <= active_d;
`ifdef PULSE_ENVELOPE_EN
         decay_q  <= decay_d;
         div_q    <= div_d;
`endif
      end
   end

   // Next-state: stop beats load, load beats timer and envelope events.
   always_comb begin
      state_d  = state_q;
      period_d = period_q;
      timer_d  = timer_q;
      duty_d   = duty_q;
      step_d   = step_q;
      vol_d    = vol_q;
`ifdef PULSE_ENVELOPE_EN
      decay_d  = decay_q;
      div_d    = div_q;
`endif
      if (i_stop_stb) begin
         state_d = StIdle;
         vol_d   = '0;
      end else if (i_load_stb) begin
         period_d = i_period;
         timer_d  = i_period;
         duty_d   = i_duty;
         step_d   = 3'd0;
         vol_d    = i_volume;
`ifdef PULSE_ENVELOPE_EN
         decay_d  = i_decay;
         div_d    = i_decay;
`endif
         state_d  = is_rest ? StIdle : StPlay;
      end else if (state_q == StPlay) begin
         // Tone timer: reload on zero and move to the next duty step.
         if (timer_q == '0) begin
            timer_d = period_q;
            step_d  = step_q + 3'd1;
         end else begin
            timer_d = timer_q - PERIOD_W'(1);
         end
`ifdef PULSE_ENVELOPE_EN
         // Envelope: the tick that brings the divider to zero drops the volume.
         if (i_tick_stb && (decay_q != 4'd0)) begin
            if (div_q <= 4'd1) begin
               div_d = decay_q;
               vol_d = vol_q - VOL_W'(1);
               if (vol_q == VOL_W'(1)) begin
                  state_d = StIdle;
               end
            end else begin
               div_d = div_q - 4'd1;
            end
         end
`endif
      end
   end

   // Duty decode of the current step.
   always_comb begin
      duty_hi = 1'b0;
      unique case (duty_q)
         2'd0:    duty_hi = (step_q == 3'd7);
         2'd1:    duty_hi = (step_q[2:1] == 2'b11);
         2'd2:    duty_hi = step_q[2];
         default: duty_hi = (step_q <= 3'd5);
      endcase
   end

   // Output stage is fed from registered state only, so outputs lag state by a cycle.
   always_comb begin
      active_d = (state_q == StPlay);
      sample_d = '0;
      if ((state_q == StPlay) && duty_hi) begin
         sample_d = vol_q;
      end
   end

   assign o_sample = sample_q;
   assign o_active = active_q;

endmodule
